// File: rtl/copy_pkg.sv
// Shared types and constants for the copy scheduler and the top_copy engine it drives.
package copy_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_WIDTH  = 16;
    localparam logic [15:0] SENTINEL = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        LOAD,
        RUN,
        REPORT
    } state_t;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_DONE    = 2'b01;
    localparam logic [1:0] ST_FULL    = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    // FULL outranks DONE when the engine raises both in the same cycle.
    function automatic logic [1:0] run_status(input logic full, input logic done,
                                              input logic expired);
        if (full)         return ST_FULL;
        else if (done)    return ST_DONE;
        else if (expired) return ST_TIMEOUT;
        else              return ST_NONE;
    endfunction

endpackage

// File: rtl/copy_sched_if.sv
// Client request/completion signals plus the engine control/status pair.
// Handshake: a client raises req[i] with its addresses stable and holds them until it sees
// ack[i] (one-cycle pulse); cmpl_valid[i] pulses once per accepted job with cmpl_status.
interface copy_sched_if
    import copy_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [1:0]        req;
    logic [ADDR_W-1:0] req_src0;
    logic [ADDR_W-1:0] req_dst0;
    logic [ADDR_W-1:0] req_src1;
    logic [ADDR_W-1:0] req_dst1;
    logic [1:0]        ack;
    logic [1:0]        cmpl_valid;
    logic [1:0]        cmpl_status;
    logic              busy;
    logic              eng_rst;
    logic [ADDR_W-1:0] eng_src;
    logic [ADDR_W-1:0] eng_dst;
    logic              eng_done;
    logic              eng_full;
    state_t            dbg_state;

    modport master (
        output req, req_src0, req_dst0, req_src1, req_dst1, eng_done, eng_full,
        input  ack, cmpl_valid, cmpl_status, busy, eng_rst, eng_src, eng_dst, dbg_state
    );

    modport slave (
        input  req, req_src0, req_dst0, req_src1, req_dst1, eng_done, eng_full,
        output ack, cmpl_valid, cmpl_status, busy, eng_rst, eng_src, eng_dst, dbg_state
    );

endinterface

// File: rtl/copy_sched_rr_arb2.sv
// Two-way round-robin pick: the pointed-to client wins if requesting, otherwise the other.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic       valid_o,
    output logic       grant_o
);

    assign valid_o = |req_i;
    assign grant_o = req_i[ptr_i] ? ptr_i : ~ptr_i;

endmodule

// File: rtl/copy_sched.sv
// Shares one top_copy engine between two clients: arbitrate, hold the engine in reset for
// setup, release it, watch done/full under a watchdog, then report per-client status.
module copy_sched
    import copy_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int TIMEOUT_CYC = 300,
    parameter int CNT_W       = 9
) (
    input  logic         clk,
    input  logic         rst,
    copy_sched_if.slave  bus
);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              rr_q, rr_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0]        cmpl_valid_q, cmpl_valid_d;
    logic [1:0]        cmpl_status_q, cmpl_status_d;
    logic              busy_q, busy_d;
    logic              eng_rst_q, eng_rst_d;
    logic [ADDR_W-1:0] eng_src_q, eng_src_d;
    logic [ADDR_W-1:0] eng_dst_q, eng_dst_d;
    logic [CNT_W-1:0]  wd_q, wd_d;
    logic [1:0]        run_st;
    logic              arb_valid;
    logic              arb_grant;

    rr_arb2 u_arb (
        .req_i   (bus.req),
        .ptr_i   (rr_q),
        .valid_o (arb_valid),
        .grant_o (arb_grant)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_d          = rr_q;
        ack_d         = 2'b00;
        cmpl_valid_d  = 2'b00;
        cmpl_status_d = ST_NONE;
        busy_d        = busy_q;
        eng_rst_d     = 1'b1;
        eng_src_d     = eng_src_q;
        eng_dst_d     = eng_dst_q;
        wd_d          = wd_q;
        run_st        = ST_NONE;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    owner_d          = arb_grant;
                    ack_d[arb_grant] = 1'b1;
                    eng_src_d        = arb_grant ? bus.req_src1 : bus.req_src0;
                    eng_dst_d        = arb_grant ? bus.req_dst1 : bus.req_dst0;
                    busy_d           = 1'b1;
                    state_d          = GRANT;
                end
            end
            GRANT: state_d = LOAD;
            LOAD: begin
                wd_d      = '0;
                eng_rst_d = 1'b0;
                state_d   = RUN;
            end
            RUN: begin
                eng_rst_d = 1'b0;
                wd_d      = wd_q + 1'b1;
                run_st    = run_status(bus.eng_full, bus.eng_done,
                                       wd_q == CNT_W'(TIMEOUT_CYC - 1));
                if (run_st != ST_NONE) begin
                    eng_rst_d             = 1'b1;
                    cmpl_valid_d[owner_q] = 1'b1;
                    cmpl_status_d         = run_st;
                    state_d               = REPORT;
                end
            end
            REPORT: begin
                rr_d    = ~owner_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            rr_q          <= 1'b0;
            ack_q         <= 2'b00;
            cmpl_valid_q  <= 2'b00;
            cmpl_status_q <= ST_NONE;
            busy_q        <= 1'b0;
            eng_rst_q     <= 1'b1;
            eng_src_q     <= '0;
            eng_dst_q     <= '0;
            wd_q          <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_q          <= rr_d;
            ack_q         <= ack_d;
            cmpl_valid_q  <= cmpl_valid_d;
            cmpl_status_q <= cmpl_status_d;
            busy_q        <= busy_d;
            eng_rst_q     <= eng_rst_d;
            eng_src_q     <= eng_src_d;
            eng_dst_q     <= eng_dst_d;
            wd_q          <= wd_d;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.cmpl_valid  = cmpl_valid_q;
    assign bus.cmpl_status = cmpl_status_q;
    assign bus.busy        = busy_q;
    assign bus.eng_rst     = eng_rst_q;
    assign bus.eng_src     = eng_src_q;
    assign bus.eng_dst     = eng_dst_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: doc/copy_sched.md
Name: copy_sched

Overview:
Two-requester scheduler that shares one top_copy engine (src/dst memories, sentinel-terminated copy).
- Accepts copy jobs (src_start, dst_start) from two clients.
- Arbitrates round-robin.
- Sequences the engine through reset/load/run.
- Watches done/full with a watchdog, then returns a per-client completion status.
- Sits directly above top_copy; drives its rst, src_start and dst_start inputs.

Parameters:
ADDR_W, 12, engine address width
TIMEOUT_CYC, 300, max RUN cycles before the job is aborted
CNT_W, 9, watchdog counter width; must hold TIMEOUT_CYC

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  2  per-client job request; held with addresses until ack
req_src0  in  ADDR_W  client 0 source start
req_dst0  in  ADDR_W  client 0 destination start
req_src1  in  ADDR_W  client 1 source start
req_dst1  in  ADDR_W  client 1 destination start
ack  out  2  one-cycle pulse: job accepted, addresses captured
cmpl_valid  out  2  one-cycle pulse to the owning client: job finished
cmpl_status  out  2  valid with cmpl_valid: 01 DONE, 10 FULL, 11 TIMEOUT
busy  out  1  engine owned by a job
eng_rst  out  1  to top_copy rst
eng_src  out  ADDR_W  to top_copy src_start
eng_dst  out  ADDR_W  to top_copy dst_start
eng_done  in  1  from top_copy done
eng_full  in  1  from top_copy full

Behaviour:
Interface basics
- One clock, clk; reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values: ack=0, cmpl_valid=0, cmpl_status=00, busy=0, eng_rst=1, eng_src=0, eng_dst=0, rr_ptr=0, state=IDLE.
- eng_rst stays 1 in every state except RUN. The engine is therefore held in reset whenever no job owns it.

FSM states: IDLE -> GRANT -> LOAD -> RUN -> REPORT -> IDLE.
- IDLE: if any req bit is set, pick the winner.
  - Winner is rr_ptr if its req is set, else the other client.
  - Capture the winner's src/dst into eng_src/eng_dst and record the owner.
  - ack[owner]=1 for exactly this transition cycle.
  - Go to GRANT.
- GRANT: one cycle with eng_rst=1 and addresses stable (engine setup). busy=1. Go to LOAD.
- LOAD: one more reset cycle. Clear the watchdog. Go to RUN.
  - Guarantees at least 2 rst cycles with stable addresses before release.
- RUN: eng_rst=0; watchdog increments every cycle.
  - If eng_full=1: status FULL. FULL wins if done and full are both set in the same cycle.
  - Else if eng_done=1: status DONE.
  - Else if watchdog reaches TIMEOUT_CYC-1: status TIMEOUT.
  - Any of these: latch the status, set eng_rst=1 on the next edge, go to REPORT.
- REPORT: cmpl_valid[owner]=1 and cmpl_status for one cycle. rr_ptr <= ~owner. busy=0 on exit. Go to IDLE.
- After REPORT the engine stays in reset, so done/full from the finished job are cleared before the next job.

Requester rules and boundary cases
- req may drop only after ack; dropping earlier is a protocol violation with undefined results.
- A client may re-request in the cycle after its ack. Its new job waits until IDLE.
- Back-to-back: minimum spacing between two jobs' RUN phases is REPORT + IDLE + GRANT + LOAD = 4 cycles.
- Both clients requesting every cycle: grants strictly alternate 0,1,0,1.
- rst asserted in any state (mid-RUN included): return to IDLE with reset values, no cmpl pulse. The job in flight is lost.
- Addresses are passed through unmodified. Wrap and full detection are engine responsibilities.

Decomposition:
- Package copy_pkg:
  - state enum (IDLE, GRANT, LOAD, RUN, REPORT)
  - status codes ST_DONE=2'b01, ST_FULL=2'b10, ST_TIMEOUT=2'b11
  - default ADDR_W=12, WIDTH=16
  - SENTINEL=16'hFFFF (shared with the engine)
- One natural sub-module: rr_arb2 (2-way round-robin grant with pointer input).
- Top-level bench wraps copy_sched + top_copy as copy_sys.

Test Plan:
1. Client 0 only, src=0, dst=100, src mem {1234,ABCD,0ACE,FFFF} -> ack[0] pulse, ≥2 eng_rst cycles, then cmpl_valid[0] with status 01; dst[100..102] = 1234, ABCD, 0ACE.
2. Both clients request in the same cycle (c0 src=10/dst=200, c1 src=20/dst=300), rr_ptr=0 -> client 0 acked first, client 1 second; each gets its own cmpl_valid with status 01; no overlap of busy periods.
3. Client 1 job with dst=4094, src {1111,2222,FFFF} -> cmpl_status 10 (FULL) to client 1; scheduler returns to IDLE and the next job runs normally.
4. eng_done and eng_full forced to 0 during RUN -> cmpl_status 11 exactly TIMEOUT_CYC cycles after RUN entry; eng_rst re-asserted.
5. Both clients hold req continuously for 6 jobs -> ack order 0,1,0,1,0,1; RUN-to-RUN gap is 4 cycles after each completion.
6. rst asserted mid-RUN -> next cycle state IDLE, eng_rst=1, busy=0, no cmpl_valid; a new request afterwards completes with status 01.
